wb_pipeline_slave_model: RTL and testbench

//  Parametrised, synthesisable Wishbone B4 pipelined slave model that terminates a NIC's node-side master port.

---
 rtl/wb_pipeline_slave_model_pkg.sv | 39 +++
 rtl/wb_slave_req_fifo.sv | 60 ++++++
 rtl/wb_pipeline_slave_model.sv | 207 ++++++++++++++++++++
 tb/tb_wb_pipeline_slave_model.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pipeline_slave_model_pkg.sv
// Shared Wishbone definitions for the pipelined slave model: CTI encodings,
// tag widths, grant FSM states and the request-entry field layout.
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 8
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 4
`endif

package wb_pipeline_slave_model_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Width of the accept timestamp and of the ack/gap countdowns.
  localparam int TS_W = 16;

  // Request entry, LSB first: dat | sel | idx | we | err | ts.
  // ts is the cycle-counter value at accept, used to credit queueing time.
  localparam int ENT_CTRL_W = 2 + TS_W;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WAIT,
    GNT_GRANT
  } gnt_state_e;

  // Countdown loaded when an entry reaches the FIFO head: remaining latency
  // after the cycles it already spent queued. Zero means "retire next edge".
  function automatic logic [TS_W-1:0] head_load(input int unsigned lat,
                                                 input logic [TS_W-1:0] queued);
    logic [31:0] l1;
    l1 = lat - 1;
    if (l1 > {16'd0, queued}) head_load = TS_W'(l1 - {16'd0, queued});
    else                      head_load = '0;
  endfunction

endpackage

// File: rtl/wb_slave_req_fifo.sv
// Synchronous request FIFO with head/next peek, full/empty flags and count.
// clr flushes all entries (used on Wishbone cycle abort).
module wb_slave_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) inc = '0;
    else                     inc = p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = store[rd_ptr];
  assign next    = store[inc(rd_ptr)];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset, occupancy is tracked above.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_pipeline_slave_model.sv
// Wishbone B4 pipelined slave model with internal memory, configurable
// read/write latency, grant delay, ack spacing and LFSR stall.
// Optional feature macro: WB_SLAVE_ERR_INJECT_EN (out-of-range word address
// terminates with ERR_O instead of ACK_O).
module wb_pipeline_slave_model
  import wb_pipeline_slave_model_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDR_WIDTH    = 32,
  parameter int          SEL_WIDTH     = 4,
  parameter int          MEM_DEPTH     = 64,
  parameter int          PEND_DEPTH    = 4,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1,
  parameter int          GNT_DELAY     = 0,
  parameter int          ACK_GAP       = 0,
  parameter int          STALL_RANDOM  = 0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      gnt_wb_o,
  input  logic                      CYC_I,
  input  logic                      STB_I,
  input  logic                      WE_I,
  input  logic [ADDR_WIDTH-1:0]     ADR_I,
  input  logic [DATA_WIDTH-1:0]     DAT_I,
  input  logic [SEL_WIDTH-1:0]      SEL_I,
  input  logic [`BUS_TGA_WIDTH-1:0] TGA_I,
  input  logic [`BUS_TGC_WIDTH-1:0] TGC_I,
  input  logic [2:0]                CTI_I,
  output logic [DATA_WIDTH-1:0]     DAT_O,
  output logic                      ACK_O,
  output logic                      RTY_O,
  output logic                      ERR_O,
  output logic                      STALL_O
);

  localparam int OFF_W   = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 0;
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int SEL_LSB = DATA_WIDTH;
  localparam int IDX_LSB = SEL_LSB + SEL_WIDTH;
  localparam int WE_BIT  = IDX_LSB + IDX_W;
  localparam int ERR_BIT = WE_BIT + 1;
  localparam int TS_LSB  = ERR_BIT + 1;
  localparam int ENT_W   = DATA_WIDTH + SEL_WIDTH + IDX_W + ENT_CTRL_W;
  localparam int CNT_W   = $clog2(PEND_DEPTH + 1);
  localparam logic [15:0]     WAIT_LOAD = (GNT_DELAY > 0) ? 16'(GNT_DELAY - 1) : 16'd0;
  localparam logic [TS_W-1:0] GAP_LOAD  = TS_W'(ACK_GAP);

  gnt_state_e state, state_nx;
  logic [15:0]           wait_cnt;
  logic                  grant;
  logic [15:0]           lfsr;
  logic                  stall_rand;
  logic [TS_W-1:0]       tick;
  logic                  accept, retire, req_err;
  logic [ENT_W-1:0]      push_ent, head_ent, next_ent;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [TS_W-1:0]       ack_cnt, gap_cnt;
  logic                  h_we, h_err, n_we;
  logic [IDX_W-1:0]      h_idx;
  logic [SEL_WIDTH-1:0]  h_sel;
  logic [DATA_WIDTH-1:0] h_dat;
  logic [TS_W-1:0]       n_ts;
  logic                  unused;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

  function automatic int unsigned lat_of(input logic w);
    lat_of = w ? WRITE_LATENCY : READ_LATENCY;
  endfunction

  // ---------------- grant FSM ----------------
  assign grant    = (state == GNT_GRANT);
  assign gnt_wb_o = grant;

  // Grant state register and grant-delay counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GNT_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == GNT_IDLE)  wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != 0) wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Grant next-state: dropping CYC_I always returns to IDLE.
  always_comb begin
    state_nx = state;
    if (!CYC_I) state_nx = GNT_IDLE;
    else begin
      case (state)
        GNT_IDLE:  state_nx = (GNT_DELAY == 0) ? GNT_GRANT : GNT_WAIT;
        GNT_WAIT:  if (wait_cnt == 0) state_nx = GNT_GRANT;
        GNT_GRANT: state_nx = GNT_GRANT;
        default:   state_nx = GNT_IDLE;
      endcase
    end
  end

  // ---------------- stall / accept ----------------
  // Free-running LFSR (x^16+x^14+x^13+x^11) and accept timestamp counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
      if (STALL_RANDOM != 0) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall_rand = (STALL_RANDOM != 0) & lfsr[0];
  assign STALL_O    = ~grant | fifo_full | stall_rand;
  assign accept     = grant & CYC_I & STB_I & ~STALL_O;
  assign RTY_O      = 1'b0;

`ifdef WB_SLAVE_ERR_INJECT_EN
  assign req_err = |ADR_I[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign h_err   = head_ent[ERR_BIT];
`else
  assign req_err = 1'b0;
  assign h_err   = 1'b0;
`endif

  assign push_ent = {tick, req_err, WE_I, ADR_I[OFF_W +: IDX_W], SEL_I, DAT_I};

  wb_slave_req_fifo #(.WIDTH(ENT_W), .DEPTH(PEND_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (~CYC_I),
    .push  (accept),
    .din   (push_ent),
    .pop   (retire),
    .head  (head_ent),
    .next  (next_ent),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign h_dat = head_ent[DATA_WIDTH-1:0];
  assign h_sel = head_ent[SEL_LSB +: SEL_WIDTH];
  assign h_idx = head_ent[IDX_LSB +: IDX_W];
  assign h_we  = head_ent[WE_BIT];
  assign n_we  = next_ent[WE_BIT];
  assign n_ts  = next_ent[TS_LSB +: TS_W];

  // Tags, low/upper address bits and untouched entry fields carry no function here.
  assign unused = ^{TGA_I, TGC_I, ADR_I, head_ent, next_ent};

  // ---------------- ack engine ----------------
  assign retire = ~fifo_empty & CYC_I & (ack_cnt == 0) & (gap_cnt == 0);

  // Head countdown, ack spacing and the one-cycle termination pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_cnt <= '0;
      gap_cnt <= '0;
      ACK_O   <= 1'b0;
      ERR_O   <= 1'b0;
      DAT_O   <= '0;
    end else begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      DAT_O <= '0;
      if (!CYC_I) begin
        ack_cnt <= '0;
        gap_cnt <= '0;
      end else begin
        if (retire) begin
          gap_cnt <= GAP_LOAD;
          if (h_err) ERR_O <= 1'b1;
          else begin
            ACK_O <= 1'b1;
            if (!h_we) DAT_O <= mem[h_idx];
          end
        end else if (gap_cnt != 0) begin
          gap_cnt <= gap_cnt - 1'b1;
        end
        if (retire && int'(fifo_count) >= 2)
          ack_cnt <= head_load(lat_of(n_we), tick - n_ts);
        else if (accept && (fifo_empty || (retire && int'(fifo_count) == 1)))
          ack_cnt <= head_load(lat_of(WE_I), '0);
        else if (ack_cnt != 0)
          ack_cnt <= ack_cnt - 1'b1;
      end
    end
  end

  // Memory update on write retirement, byte lanes gated by SEL.
  always_ff @(posedge clk) begin
    if (!rst && retire && h_we && !h_err)
      for (int b = 0; b < SEL_WIDTH; b++)
        if (h_sel[b]) mem[h_idx][8*b +: 8] <= h_dat[8*b +: 8];
  end

  // CTI is otherwise ignored; flag encodings this model does not understand.
  always_ff @(posedge clk) begin
    if (!rst && accept)
      assert (CTI_I == CTI_CLASSIC || CTI_I == CTI_INCR || CTI_I == CTI_EOB);
  end

endmodule

// File: tb/tb_wb_pipeline_slave_model.sv
// Directed bench for wb_pipeline_slave_model: three instances (defaults,
// grant delay + ack gap, long read latency) driven by one linear sequence.
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 8
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 4
`endif

module tb_wb_pipeline_slave_model;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  logic gnt [N], cyc [N], stb [N], we [N], ack [N], rty [N], err [N], stall [N];
  logic [31:0] adr [N], wdat [N], rdat [N];
  logic [3:0]  sel [N];
  logic [`BUS_TGA_WIDTH-1:0] tga;
  logic [`BUS_TGC_WIDTH-1:0] tgc;
  logic [2:0] cti;

  int n_pass = 0, n_tot = 0, n_fail = 0;

  always #5 clk = ~clk;

  wb_pipeline_slave_model u_def (
    .clk(clk), .rst(rst), .gnt_wb_o(gnt[0]), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]),
    .ADR_I(adr[0]), .DAT_I(wdat[0]), .SEL_I(sel[0]), .TGA_I(tga), .TGC_I(tgc), .CTI_I(cti),
    .DAT_O(rdat[0]), .ACK_O(ack[0]), .RTY_O(rty[0]), .ERR_O(err[0]), .STALL_O(stall[0]));

  wb_pipeline_slave_model #(.GNT_DELAY(3), .ACK_GAP(2)) u_gap (
    .clk(clk), .rst(rst), .gnt_wb_o(gnt[1]), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]),
    .ADR_I(adr[1]), .DAT_I(wdat[1]), .SEL_I(sel[1]), .TGA_I(tga), .TGC_I(tgc), .CTI_I(cti),
    .DAT_O(rdat[1]), .ACK_O(ack[1]), .RTY_O(rty[1]), .ERR_O(err[1]), .STALL_O(stall[1]));

  wb_pipeline_slave_model #(.READ_LATENCY(4)) u_lat (
    .clk(clk), .rst(rst), .gnt_wb_o(gnt[2]), .CYC_I(cyc[2]), .STB_I(stb[2]), .WE_I(we[2]),
    .ADR_I(adr[2]), .DAT_I(wdat[2]), .SEL_I(sel[2]), .TGA_I(tga), .TGC_I(tgc), .CTI_I(cti),
    .DAT_O(rdat[2]), .ACK_O(ack[2]), .RTY_O(rty[2]), .ERR_O(err[2]), .STALL_O(stall[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: wait (bounded) for acceptance, then count cycles to termination.
  task automatic do_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic [31:0] rd,
                        output logic a_o, output logic e_o);
    int b;
    stb[i] = 1'b1; we[i] = w; adr[i] = a; wdat[i] = d; sel[i] = s;
    b = 0;
    while (stall[i] && b < 20) begin step(); b++; end
    step();
    stb[i] = 1'b0;
    lat = 0;
    do begin step(); lat++; end while (!(ack[i] || err[i]) && lat < 20);
    rd = rdat[i]; a_o = ack[i]; e_o = err[i];
  endtask

  initial begin
    int lat, acc, extra, w;
    logic [31:0] rd;
    logic a, e;
    int apos [$];

    rst = 1'b1; cti = 3'b000; tga = '0; tgc = '0;
    for (int i = 0; i < N; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = 0; wdat[i] = 0; sel[i] = 0;
    end
    step(); step();
    check("rst_gnt",   gnt[0],   0);
    check("rst_ack",   ack[0],   0);
    check("rst_err",   err[0],   0);
    check("rst_rty",   rty[0],   0);
    check("rst_dat",   rdat[0],  0);
    check("rst_stall", stall[0], 1);
    rst = 1'b0;
    step();

    // Defaults: write then read back, latencies 1 and 2
    cyc[0] = 1'b1;
    step();
    check("gnt_d0",    gnt[0],   1);
    check("stall_gnt", stall[0], 0);
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, a, e);
    check("wr_lat", lat, 1);
    check("wr_ack", a,   1);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, a, e);
    check("rd_lat",  lat, 2);
    check("rd_data", rd,  32'hDEADBEEF);
    step();
    check("ack_low", ack[0],  0);
    check("dat_low", rdat[0], 0);

    // Byte lanes
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, a, e);
    do_req(0, 1'b1, 32'h20, 32'hAA000000, 4'h8, lat, rd, a, e);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, a, e);
    check("byte_lane", rd, 32'hAA223344);

    // Out-of-range address
    do_req(0, 1'b1, 32'h0, 32'h5A5A0001, 4'hF, lat, rd, a, e);
    do_req(0, 1'b0, 32'h100, 32'h0, 4'hF, lat, rd, a, e);
`ifdef WB_SLAVE_ERR_INJECT_EN
    check("oor_err",  e,  1);
    check("oor_ack",  a,  0);
    check("oor_dat",  rd, 0);
`else
    check("oor_err",  e,  0);
    check("oor_ack",  a,  1);
    check("oor_dat",  rd, 32'h5A5A0001);
`endif

    // Grant delay 3, ack gap 2
    cyc[1] = 1'b1;
    step(); step(); step();
    check("gnt_wait3", gnt[1], 0);
    step();
    check("gnt_rise4", gnt[1], 1);
    stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; wdat[1] = 32'h0BADF00D; sel[1] = 4'hF;
    acc = 0;
    for (int k = 1; k <= 16; k++) begin
      if (stb[1] && !stall[1]) acc++;
      step();
      if (acc == 3) stb[1] = 1'b0;
      if (ack[1]) apos.push_back(k);
    end
    check("gap_nacks", apos.size(), 3);
    if (apos.size() == 3) begin
      check("gap_first", apos[0], 2);
      check("gap_1_2",   apos[1] - apos[0], 3);
      check("gap_2_3",   apos[2] - apos[1], 3);
    end
    cyc[1] = 1'b0;

    // Pipeline at READ_LATENCY=4: fill FIFO, 5th stalls
    cyc[2] = 1'b1;
    step();
    check("b_gnt", gnt[2], 1);
    for (int k = 0; k < 4; k++) begin
      do_req(2, 1'b1, 32'h40 + 32'(4*k), 32'h10000000 + 32'(k), 4'hF, lat, rd, a, e);
      check("b_wr_lat", lat, 1);
    end
    stb[2] = 1'b1; we[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      adr[2] = 32'h40 + 32'(4*k);
      check("pipe_stall", stall[2], 0);
      step();
    end
    adr[2] = 32'h40;
    check("pipe_full_stall", stall[2], 1);
    step();
    check("pipe_ack0", ack[2],  1);
    check("pipe_dat0", rdat[2], 32'h10000000);
    check("pipe_unstall", stall[2], 0);
    step();
    stb[2] = 1'b0;
    check("pipe_ack1", ack[2],  1);
    check("pipe_dat1", rdat[2], 32'h10000001);
    step();
    check("pipe_ack2", ack[2],  1);
    check("pipe_dat2", rdat[2], 32'h10000002);
    step();
    check("pipe_ack3", ack[2],  1);
    check("pipe_dat3", rdat[2], 32'h10000003);
    step();
    check("pipe_idle", ack[2], 0);
    step();
    check("pipe_fifth_ack", ack[2],  1);
    check("pipe_fifth_dat", rdat[2], 32'h10000000);
    step();

    // Abort after first ack
    stb[2] = 1'b1; we[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adr[2] = 32'h40 + 32'(4*k);
      step();
    end
    stb[2] = 1'b0;
    w = 0;
    while (!ack[2] && w < 20) begin step(); w++; end
    check("abort_first_ack", ack[2],  1);
    check("abort_first_dat", rdat[2], 32'h10000000);
    cyc[2] = 1'b0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ack[2] || err[2]) extra++;
    end
    check("abort_no_ack", extra,    0);
    check("abort_gnt",    gnt[2],   0);
    check("abort_stall",  stall[2], 1);
    cyc[2] = 1'b1;
    step();
    do_req(2, 1'b0, 32'h4C, 32'h0, 4'hF, lat, rd, a, e);
    check("post_abort_lat", lat, 4);
    check("post_abort_dat", rd,  32'h10000003);

    // Reset in the middle of a burst
    step();
    stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10;
    step(); step();
    stb[0] = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_gnt",   gnt[0],   0);
    check("mid_rst_ack",   ack[0],   0);
    check("mid_rst_err",   err[0],   0);
    check("mid_rst_dat",   rdat[0],  0);
    check("mid_rst_stall", stall[0], 1);
    rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ack[0] || err[0]) extra++;
    end
    check("mid_rst_lost", extra, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
